// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: Y86 F/D/E pipeline registers with stall/bubble control and saturating event counters
module pipe_stage_regs #(
   parameter int              WORD      = 64,
   parameter logic [WORD-1:0] RESET_PC  = '0,
   parameter logic [3:0]      STAT_AOK  = 4'b1000,
   parameter logic [3:0]      NOP_ICODE = 4'h1,
   parameter logic [3:0]      REG_NONE  = 4'hF,
   parameter int              CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             F_stall,
   input  logic             D_stall,
   input  logic             D_bubble,
   input  logic             E_bubble,
   input  logic [WORD-1:0]  f_predPC,
   input  logic [3:0]       f_stat,
   input  logic [3:0]       f_icode,
   input  logic [3:0]       f_ifun,
   input  logic [3:0]       f_rA,
   input  logic [3:0]       f_rB,
   input  logic [WORD-1:0]  f_valC,
   input  logic [WORD-1:0]  f_valP,
   input  logic [3:0]       d_stat,
   input  logic [3:0]       d_icode,
   input  logic [3:0]       d_ifun,
   input  logic [WORD-1:0]  d_valC,
   input  logic [WORD-1:0]  d_valA,
   input  logic [WORD-1:0]  d_valB,
   input  logic [3:0]       d_dstE,
   input  logic [3:0]       d_dstM,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   output logic [WORD-1:0]  F_predPC,
   output logic [3:0]       D_stat,
   output logic [3:0]       D_icode,
   output logic [3:0]       D_ifun,
   output logic [3:0]       D_rA,
   output logic [3:0]       D_rB,
   output logic [WORD-1:0]  D_valC,
   output logic [WORD-1:0]  D_valP,
   output logic [3:0]       E_stat,
   output logic [3:0]       E_icode,
   output logic [3:0]       E_ifun,
   output logic [3:0]       E_dstE,
   output logic [3:0]       E_dstM,
   output logic [3:0]       E_srcA,
   output logic [3:0]       E_srcB,
   output logic [WORD-1:0]  E_valC,
   output logic [WORD-1:0]  E_valA,
   output logic [WORD-1:0]  E_valB,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);
   localparam int DW = 20 + 2 * WORD;
   localparam int EW = 28 + 3 * WORD;
   localparam logic [DW-1:0] D_NOP = {STAT_AOK, NOP_ICODE, 4'h0, REG_NONE, REG_NONE, {(2 * WORD){1'b0}}};
   localparam logic [EW-1:0] E_NOP = {STAT_AOK, NOP_ICODE, 4'h0, REG_NONE, REG_NONE, REG_NONE, REG_NONE,
                                      {(3 * WORD){1'b0}}};
   logic [WORD-1:0]  r_f_predpc;
   logic [DW-1:0]    r_d;
   logic [EW-1:0]    r_e;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;
   logic [DW-1:0]    w_d_in;
   logic [EW-1:0]    w_e_in;
   logic             w_stall;
   logic             w_bubble;
   assign w_d_in   = {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
   assign w_e_in   = {d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB, d_valC, d_valA, d_valB};
   assign w_stall  = F_stall | D_stall;
   assign w_bubble = D_bubble | E_bubble;
   // D: stall outranks bubble, so a simultaneous stall+bubble simply holds
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_f_predpc   <= RESET_PC;
         r_d          <= D_NOP;
         r_e          <= E_NOP;
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (!F_stall) r_f_predpc <= f_predPC;
         if (!D_stall) r_d <= D_bubble ? D_NOP : w_d_in;
         r_e <= E_bubble ? E_NOP : w_e_in;
         if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_bubble && !(&r_bubble_cnt)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end
   assign F_predPC = r_f_predpc;
   assign {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} = r_d;
   assign {E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_valC, E_valA, E_valB} = r_e;
   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
endmodule
